// File: rtl/taint_check.sv
// Sink-side taint checker: strips operand tags, flags tainted words, counts them and stalls in ALARM.
// Optional build macro TAINT_CHECK_MASK_EN zeroes the forwarded data of tainted words.
module taint_check #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_taint,
    input  logic             alarm_clr,
    output logic             alarm,
    output logic [CNT_W-1:0] taint_cnt
);

    typedef enum logic {
        ST_RUN,
        ST_ALARM
    } state_e;

    localparam logic [63:0]      TAG_MASK = 64'h8000_0000_8000_0000;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             out_taint_q, out_taint_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             taint;
    logic             hit;
    logic             thresh_hit;
    logic [63:0]      fwd_data;

    always_comb begin
        in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        accept     = in_valid && in_ready;
        taint      = in_data[63] | in_data[31];
        hit        = accept && taint;
        thresh_hit = (THRESH != 0) && ((32'(cnt_q) + 32'd1) >= THRESH);
`ifdef TAINT_CHECK_MASK_EN
        fwd_data   = taint ? '0 : (in_data & ~TAG_MASK);
`else
        fwd_data   = in_data & ~TAG_MASK;
`endif

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_taint_d = out_taint_q;
        cnt_d       = cnt_q;
        state_d     = state_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = fwd_data;
            out_taint_d = taint;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // alarm_clr dominates a simultaneous tainted accept in both count and state
        if (alarm_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                if (!alarm_clr && hit && thresh_hit) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (alarm_clr) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_taint_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_taint_q <= out_taint_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_taint = out_taint_q;
    assign alarm     = (state_q == ST_ALARM);
    assign taint_cnt = cnt_q;

endmodule

// File: tb/tb_taint_check.sv
// Bench for taint_check: three configurations share one stimulus stream, each against its own reference model.
module tb_taint_check;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, alarm_clr;
    logic [63:0] in_data;
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_taint [3];
    logic        alarm     [3];
    logic [63:0] out_data  [3];
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

`ifdef TAINT_CHECK_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    taint_check #(.CNT_W(16), .THRESH(1)) u_th1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_taint(out_taint[0]), .alarm_clr(alarm_clr), .alarm(alarm[0]), .taint_cnt(cnt_a));

    taint_check #(.CNT_W(16), .THRESH(3)) u_th3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_taint(out_taint[1]), .alarm_clr(alarm_clr), .alarm(alarm[1]), .taint_cnt(cnt_b));

    taint_check #(.CNT_W(2), .THRESH(0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_taint(out_taint[2]), .alarm_clr(alarm_clr), .alarm(alarm[2]), .taint_cnt(cnt_c));

    int checks = 0;
    int errors = 0;

    // reference state per instance: one pending output word, alarm flag, tainted count
    bit          m_ov  [3];
    logic [63:0] m_od  [3];
    bit          m_ot  [3];
    bit          m_al  [3];
    int unsigned m_cnt [3];

    function automatic int unsigned th_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    function automatic int unsigned cmax_of(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    function automatic logic [63:0] dut_cnt(input int k);
        return (k == 0) ? 64'(cnt_a) : (k == 1) ? 64'(cnt_b) : 64'(cnt_c);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0; m_od[k] = 64'h0; m_ot[k] = 1'b0; m_al[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_ov[k]));
            check($sformatf("out_data[%0d]", k),  out_data[k],        m_od[k]);
            check($sformatf("out_taint[%0d]", k), 64'(out_taint[k]), 64'(m_ot[k]));
            check($sformatf("alarm[%0d]", k),     64'(alarm[k]),     64'(m_al[k]));
            check($sformatf("taint_cnt[%0d]", k), dut_cnt(k),        64'(m_cnt[k]));
        end
    endtask

    // one clock: drive inputs, check combinational ready, advance model, check registered outputs
    task automatic step(input bit r, input bit v, input logic [63:0] d, input bit ordy, input bit clr);
        bit          rdy, acc, t;
        int unsigned old;
        rst = r; in_valid = v; in_data = d; out_ready = ordy; alarm_clr = clr;
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy = !m_al[k] && (!m_ov[k] || ordy);
            check($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(rdy));
            acc = v && rdy;
            t   = d[63] | d[31];
            if (r) begin
                m_ov[k] = 1'b0; m_od[k] = 64'h0; m_ot[k] = 1'b0; m_al[k] = 1'b0; m_cnt[k] = 0;
            end else begin
                if (acc) begin
                    m_ov[k] = 1'b1;
                    m_ot[k] = t;
                    m_od[k] = (MASK_EN && t) ? 64'h0 : (d & 64'h7FFF_FFFF_7FFF_FFFF);
                end else if (ordy) begin
                    m_ov[k] = 1'b0;
                end
                old = m_cnt[k];
                if (clr) m_cnt[k] = 0;
                else if (acc && t && m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
                if (clr) m_al[k] = 1'b0;
                else if (acc && t && th_of(k) != 0 && old + 1 >= th_of(k)) m_al[k] = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [63:0] d;
        rst = 1'b1; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b1; alarm_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outputs();

        // untainted word passes unchanged with one cycle latency
        step(0, 1, 64'h1234_5678_0000_0001, 1, 0);
        check("pass_valid", 64'(out_valid[0]), 64'd1);
        check("pass_data", out_data[0], 64'h1234_5678_0000_0001);
        check("pass_taint", 64'(out_taint[0]), 64'd0);
        check("pass_cnt", 64'(cnt_a), 64'd0);

        // tainted word with THRESH=1 raises alarm and drops ready immediately
        step(0, 1, 64'h8000_0005_8000_0003, 1, 0);
        check("taint_data", out_data[0], MASK_EN ? 64'h0 : 64'h0000_0005_0000_0003);
        check("taint_flag", 64'(out_taint[0]), 64'd1);
        check("taint_cnt", 64'(cnt_a), 64'd1);
        check("taint_alarm", 64'(alarm[0]), 64'd1);
        check("alarm_ready", 64'(in_ready[0]), 64'd0);

        for (int i = 0; i < 5; i++) step(0, 1, 64'h0000_0007_0000_0009, 1, 0);
        check("alarm_hold_cnt", 64'(cnt_a), 64'd1);
        check("alarm_hold", 64'(alarm[0]), 64'd1);

        step(0, 0, 64'h0, 1, 1);
        check("clr_alarm", 64'(alarm[0]), 64'd0);
        check("clr_cnt", 64'(cnt_a), 64'd0);
        check("clr_ready", 64'(in_ready[0]), 64'd1);

        // backpressure: held word stays stable, then handoff and new accept in one cycle
        step(0, 1, 64'h1111_2222_3333_4444, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 64'h0, 0, 0);
        check("bp_data", out_data[0], 64'h1111_2222_3333_4444);
        check("bp_ready", 64'(in_ready[0]), 64'd0);
        step(0, 1, 64'h0123_4567_0765_4321, 1, 0);
        check("handoff_data", out_data[0], 64'h0123_4567_0765_4321);

        // THRESH=3 with clear in the middle of three tainted words
        step(0, 0, 64'h0, 1, 1);
        step(0, 1, 64'h8000_0001_8000_0001, 1, 0);
        check("th3_cnt1", 64'(cnt_b), 64'd1);
        step(0, 1, 64'h0000_0002_8000_0002, 1, 1);
        check("th3_cnt0", 64'(cnt_b), 64'd0);
        check("th3_taint_clr", 64'(out_taint[1]), 64'd1);
        step(0, 1, 64'h8000_0003_0000_0003, 1, 0);
        check("th3_cnt1b", 64'(cnt_b), 64'd1);
        check("th3_no_alarm", 64'(alarm[1]), 64'd0);

        // CNT_W=2 saturation with alarm disabled
        step(0, 0, 64'h0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 64'h8000_0000_0000_0010 + 64'(i), 1, 0);
        check("sat_cnt", 64'(cnt_c), 64'd3);
        check("sat_no_alarm", 64'(alarm[2]), 64'd0);
        check("pre_rst_valid", 64'(out_valid[2]), 64'd1);
        step(1, 0, 64'h0, 0, 0);
        check("rst_valid", 64'(out_valid[2]), 64'd0);
        step(0, 0, 64'h0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            d = {$urandom, $urandom};
            d[63] = ($urandom_range(0, 3) == 0);
            d[31] = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, d,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
